// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch controller: FSM encoding, RS ids, width.
package dispatch_pkg;

  localparam int DISP_W = 4;

  localparam logic RS_ID_ALU = 1'b0;
  localparam logic RS_ID_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Bundle of decode-side inputs and dispatch-side outputs of the dispatch controller.
interface dispatch_ctrl_if #(
  parameter int CW = 4
);
  import dispatch_pkg::*;

  logic              flush_i;
  logic [DISP_W-1:0] inst_vld_i;
  logic [DISP_W-1:0] inst_rs_id_i;
  logic [DISP_W-1:0] inst_illegal_i;
  logic              ren_rdy_i;
  logic [2:0]        rs0_rel_cnt_i;
  logic [2:0]        rs1_rel_cnt_i;

  logic [DISP_W-1:0] dispatch_vld_o;
  logic [2:0]        rm_cnt_o;
  logic [CW-1:0]     rs0_credit_o;
  logic [CW-1:0]     rs1_credit_o;
  logic              stall_o;
  logic              exc_o;
  logic [1:0]        state_o;

  // Decode/buffer side drives the instruction view and reads dispatch results.
  modport master (
    output flush_i, inst_vld_i, inst_rs_id_i, inst_illegal_i, ren_rdy_i,
           rs0_rel_cnt_i, rs1_rel_cnt_i,
    input  dispatch_vld_o, rm_cnt_o, rs0_credit_o, rs1_credit_o, stall_o,
           exc_o, state_o
  );

  // The dispatch controller itself.
  modport slave (
    input  flush_i, inst_vld_i, inst_rs_id_i, inst_illegal_i, ren_rdy_i,
           rs0_rel_cnt_i, rs1_rel_cnt_i,
    output dispatch_vld_o, rm_cnt_o, rs0_credit_o, rs1_credit_o, stall_o,
           exc_o, state_o
  );

endinterface

// File: rtl/dispatch_ctrl_rs_credit_cnt.sv
// Saturating free-entry counter for one reservation station.
module rs_credit_cnt #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic [2:0]    disp_cnt,
  input  logic [2:0]    rel_cnt,
  output logic [CW-1:0] credit
);

  localparam int SW = CW + 4;

  logic signed [SW-1:0] sum;

  // Unsaturated next credit, signed so underflow is visible.
  always_comb begin
    sum = $signed(SW'(credit)) - $signed(SW'(disp_cnt)) + $signed(SW'(rel_cnt));
  end

  // Reload on flush (the RS empties alongside us), otherwise clamp into 0..DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credit <= CW'(DEPTH);
    end else if (flush) begin
      credit <= CW'(DEPTH);
    end else if (sum > $signed(SW'(DEPTH))) begin
      credit <= CW'(DEPTH);
    end else if (sum < 0) begin
      credit <= '0;
    end else begin
      credit <= sum[CW-1:0];
    end
  end

  credit_range_a : assert property (@(posedge clock) disable iff (reset)
    !flush |-> (sum >= 0 && sum <= $signed(SW'(DEPTH))));

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order 4-wide dispatch controller feeding two reservation stations.
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int RS0_DEPTH   = 8,
  parameter int RS1_DEPTH   = 8,
  parameter int RECOVER_CYC = 2
) (
  input logic           clock,
  input logic           reset,
  dispatch_ctrl_if.slave bus
);

  localparam int CW  = $clog2(((RS0_DEPTH > RS1_DEPTH) ? RS0_DEPTH : RS1_DEPTH) + 1);
  localparam int RCW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  state_t            state, state_next;
  logic [RCW-1:0]    rcnt, rcnt_next;
  logic [DISP_W-1:0] disp;
  logic [2:0]        used0, used1;
  logic              halt_hit, blocked, credit_ok;
  logic [CW-1:0]     credit0, credit1;

  // Walk the slots oldest-first; the first slot that cannot leave blocks all younger ones.
  always_comb begin
    disp      = '0;
    used0     = '0;
    used1     = '0;
    halt_hit  = 1'b0;
    blocked   = 1'b0;
    credit_ok = 1'b0;
    for (int k = 0; k < DISP_W; k++) begin
      if (state == ST_RUN && !bus.flush_i && !blocked) begin
        if (bus.inst_rs_id_i[k] == RS_ID_ALU) begin
          credit_ok = ({{CW{1'b0}}, used0} < {3'b000, credit0});
        end else begin
          credit_ok = ({{CW{1'b0}}, used1} < {3'b000, credit1});
        end
        if (bus.inst_vld_i[k] && bus.inst_illegal_i[k]) begin
          halt_hit = 1'b1;
          blocked  = 1'b1;
        end else if (bus.ren_rdy_i && bus.inst_vld_i[k] && credit_ok) begin
          disp[k] = 1'b1;
          if (bus.inst_rs_id_i[k] == RS_ID_ALU) begin
            used0 = used0 + 3'd1;
          end else begin
            used1 = used1 + 3'd1;
          end
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  // State and recovery counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_RECOVER;
      rcnt  <= RCW'(RECOVER_CYC - 1);
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
    end
  end

  // Flush overrides everything; RECOVER counts down, HALT waits for a flush.
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    if (bus.flush_i) begin
      state_next = ST_RECOVER;
      rcnt_next  = RCW'(RECOVER_CYC - 1);
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_hit) state_next = ST_HALT;
        end
        ST_RECOVER: begin
          if (rcnt == '0) state_next = ST_RUN;
          else            rcnt_next  = rcnt - 1'b1;
        end
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_RECOVER;
      endcase
    end
  end

  // Outputs derived from the dispatch decision and the current state.
  always_comb begin
    bus.dispatch_vld_o = disp;
    bus.rm_cnt_o       = used0 + used1;
    bus.stall_o        = (state == ST_RUN) && bus.inst_vld_i[0] && !disp[0];
    bus.exc_o          = (state == ST_HALT);
    bus.state_o        = state;
    bus.rs0_credit_o   = credit0;
    bus.rs1_credit_o   = credit1;
  end

  rs_credit_cnt #(.DEPTH(RS0_DEPTH), .CW(CW)) u_rs0_credit (
    .clock    (clock),
    .reset    (reset),
    .flush    (bus.flush_i),
    .disp_cnt (used0),
    .rel_cnt  (bus.rs0_rel_cnt_i),
    .credit   (credit0)
  );

  rs_credit_cnt #(.DEPTH(RS1_DEPTH), .CW(CW)) u_rs1_credit (
    .clock    (clock),
    .reset    (reset),
    .flush    (bus.flush_i),
    .disp_cnt (used1),
    .rel_cnt  (bus.rs1_rel_cnt_i),
    .credit   (credit1)
  );

  vld_prefix_a : assert property (@(posedge clock) disable iff (reset)
    (bus.inst_vld_i & 4'(bus.inst_vld_i + 4'd1)) == 4'd0);

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed self-checking bench for dispatch_ctrl (depths 8/8, two recovery cycles).
module tb_dispatch_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  dispatch_ctrl_if #(.CW(4)) bus ();

  dispatch_ctrl #(.RS0_DEPTH(8), .RS1_DEPTH(8), .RECOVER_CYC(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Move to the falling edge so the next rising edge has committed.
  task automatic nextCycle();
    @(negedge clock);
  endtask

  // Drive one cycle of inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic [3:0] vld, input logic [3:0] rs,
                               input logic [3:0] ill, input logic ren,
                               input logic flush, input logic [2:0] rel0,
                               input logic [2:0] rel1);
    bus.inst_vld_i     = vld;
    bus.inst_rs_id_i   = rs;
    bus.inst_illegal_i = ill;
    bus.ren_rdy_i      = ren;
    bus.flush_i        = flush;
    bus.rs0_rel_cnt_i  = rel0;
    bus.rs1_rel_cnt_i  = rel1;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0);
    nextCycle();
    #1;
    checkOutput("rst_state", 32'(bus.state_o), 32'd1);
    checkOutput("rst_cr0", 32'(bus.rs0_credit_o), 32'd8);
    checkOutput("rst_cr1", 32'(bus.rs1_credit_o), 32'd8);
    checkOutput("rst_disp", 32'(bus.dispatch_vld_o), 32'd0);
    checkOutput("rst_rm", 32'(bus.rm_cnt_o), 32'd0);
    checkOutput("rst_stall", 32'(bus.stall_o), 32'd0);
    checkOutput("rst_exc", 32'(bus.exc_o), 32'd0);

    // Two recovery cycles after reset, then a full-width dispatch to RS0.
    nextCycle();
    reset = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("rec1_disp", 32'(bus.dispatch_vld_o), 32'd0);
    checkOutput("rec1_state", 32'(bus.state_o), 32'd1);
    nextCycle();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("rec2_disp", 32'(bus.dispatch_vld_o), 32'd0);
    nextCycle();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("run_state", 32'(bus.state_o), 32'd0);
    checkOutput("run_disp", 32'(bus.dispatch_vld_o), 32'hf);
    checkOutput("run_rm", 32'(bus.rm_cnt_o), 32'd4);
    checkOutput("run_cr0", 32'(bus.rs0_credit_o), 32'd8);
    nextCycle();
    applyStimulus(4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("cr0_after4", 32'(bus.rs0_credit_o), 32'd4);
    checkOutput("two_disp", 32'(bus.dispatch_vld_o), 32'h3);
    checkOutput("two_rm", 32'(bus.rm_cnt_o), 32'd2);

    // Mixed targets with only two RS0 credits: slot 3 runs out.
    nextCycle();
    applyStimulus(4'b1111, 4'b0100, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("mix_cr0", 32'(bus.rs0_credit_o), 32'd2);
    checkOutput("mix_disp", 32'(bus.dispatch_vld_o), 32'h7);
    checkOutput("mix_rm", 32'(bus.rm_cnt_o), 32'd3);
    checkOutput("mix_stall", 32'(bus.stall_o), 32'd0);

    // Zero credit with a same-cycle release stays blocked this cycle.
    nextCycle();
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd3, 3'd0);
    checkOutput("zero_cr0", 32'(bus.rs0_credit_o), 32'd0);
    checkOutput("zero_cr1", 32'(bus.rs1_credit_o), 32'd7);
    checkOutput("zero_disp", 32'(bus.dispatch_vld_o), 32'd0);
    checkOutput("zero_stall", 32'(bus.stall_o), 32'd1);
    nextCycle();
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd1);
    checkOutput("rel_cr0", 32'(bus.rs0_credit_o), 32'd3);
    checkOutput("rel_disp", 32'(bus.dispatch_vld_o), 32'h1);
    checkOutput("rel_rm", 32'(bus.rm_cnt_o), 32'd1);
    checkOutput("rel_stall", 32'(bus.stall_o), 32'd0);

    // Drain RS0, then an RS1-bound younger slot must wait behind it.
    nextCycle();
    applyStimulus(4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("drain_cr1", 32'(bus.rs1_credit_o), 32'd8);
    checkOutput("drain_disp", 32'(bus.dispatch_vld_o), 32'h3);
    nextCycle();
    applyStimulus(4'b0011, 4'b0010, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("order_disp", 32'(bus.dispatch_vld_o), 32'd0);
    checkOutput("order_stall", 32'(bus.stall_o), 32'd1);

    // Empty buffer while RS0 frees four entries.
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd4, 3'd0);
    checkOutput("empty_rm", 32'(bus.rm_cnt_o), 32'd0);
    checkOutput("empty_stall", 32'(bus.stall_o), 32'd0);

    // Rename not ready: nothing leaves, credits hold.
    nextCycle();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0);
    checkOutput("noren_disp", 32'(bus.dispatch_vld_o), 32'd0);
    checkOutput("noren_stall", 32'(bus.stall_o), 32'd1);
    checkOutput("noren_cr0", 32'(bus.rs0_credit_o), 32'd4);

    // Illegal slot 2: slots 0 and 1 still go, then HALT.
    nextCycle();
    applyStimulus(4'b1111, 4'b1010, 4'b0100, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("ill_cr0", 32'(bus.rs0_credit_o), 32'd4);
    checkOutput("ill_disp", 32'(bus.dispatch_vld_o), 32'h3);
    checkOutput("ill_rm", 32'(bus.rm_cnt_o), 32'd2);
    checkOutput("ill_exc", 32'(bus.exc_o), 32'd0);
    nextCycle();
    applyStimulus(4'b1111, 4'b1010, 4'b0100, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("halt_state", 32'(bus.state_o), 32'd2);
    checkOutput("halt_exc", 32'(bus.exc_o), 32'd1);
    checkOutput("halt_disp", 32'(bus.dispatch_vld_o), 32'd0);
    checkOutput("halt_stall", 32'(bus.stall_o), 32'd0);
    checkOutput("halt_cr0", 32'(bus.rs0_credit_o), 32'd3);
    checkOutput("halt_cr1", 32'(bus.rs1_credit_o), 32'd7);

    // Flush out of HALT; the RS0 release during flush is ignored.
    nextCycle();
    applyStimulus(4'b1111, 4'b1010, 4'b0100, 1'b1, 1'b1, 3'd1, 3'd0);
    checkOutput("fl_disp", 32'(bus.dispatch_vld_o), 32'd0);
    checkOutput("fl_exc", 32'(bus.exc_o), 32'd1);
    nextCycle();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("flr_state", 32'(bus.state_o), 32'd1);
    checkOutput("flr_exc", 32'(bus.exc_o), 32'd0);
    checkOutput("flr_cr0", 32'(bus.rs0_credit_o), 32'd8);
    checkOutput("flr_cr1", 32'(bus.rs1_credit_o), 32'd8);
    checkOutput("flr_disp", 32'(bus.dispatch_vld_o), 32'd0);
    nextCycle();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("flr2_disp", 32'(bus.dispatch_vld_o), 32'd0);
    nextCycle();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("rerun_disp", 32'(bus.dispatch_vld_o), 32'hf);
    nextCycle();
    applyStimulus(4'b1111, 4'b1110, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
    checkOutput("rerun2_disp", 32'(bus.dispatch_vld_o), 32'hf);

    // Asynchronous reset mid-RUN with credits 3/5.
    nextCycle();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0);
    checkOutput("pre_cr0", 32'(bus.rs0_credit_o), 32'd3);
    checkOutput("pre_cr1", 32'(bus.rs1_credit_o), 32'd5);
    checkOutput("pre_state", 32'(bus.state_o), 32'd0);
    bus.ren_rdy_i = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_state", 32'(bus.state_o), 32'd1);
    checkOutput("arst_cr0", 32'(bus.rs0_credit_o), 32'd8);
    checkOutput("arst_cr1", 32'(bus.rs1_credit_o), 32'd8);
    checkOutput("arst_disp", 32'(bus.dispatch_vld_o), 32'd0);
    checkOutput("arst_rm", 32'(bus.rm_cnt_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- In-order dispatch controller between the instruction buffer/4-wide decoders and the two reservation stations (RS0, RS1).
- Each cycle it picks the longest in-order prefix of the 4 decoded slots that can leave: slot valid, legal, rename ready, and a credit free in its target RS.
- It drives the buffer-removal count and tracks per-RS credits.
- It sequences flush recovery and halts dispatch at an illegal instruction until flushed.

Parameters:
- RS0_DEPTH, 8, entries in reservation station 0 (initial/max credit).
- RS1_DEPTH, 8, entries in reservation station 1.
- RECOVER_CYC, 2, dispatch-blocked cycles after flush (>=1).
- CW, $clog2(max(RS0_DEPTH,RS1_DEPTH)+1), credit counter width (derived, not overridable).

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  pipeline flush; highest priority.
- inst_vld_i  in  4  decoded slot k holds a buffered instruction; must be a prefix mask (0000,0001,0011,0111,1111).
- inst_rs_id_i  in  4  target RS per slot (0=RS0, 1=RS1).
- inst_illegal_i  in  4  per-slot illegal-instruction flag.
- ren_rdy_i  in  1  rename stage can accept this cycle.
- rs0_rel_cnt_i  in  3  RS0 entries freed this cycle (0..4).
- rs1_rel_cnt_i  in  3  RS1 entries freed this cycle (0..4).
- dispatch_vld_o  out  4  slots dispatched this cycle (prefix mask).
- rm_cnt_o  out  3  instructions to pop from the buffer (popcount of dispatch_vld_o).
- rs0_credit_o  out  CW  current free RS0 entries.
- rs1_credit_o  out  CW  current free RS1 entries.
- stall_o  out  1  slot0 valid but not dispatched, state RUN.
- exc_o  out  1  illegal-instruction exception; level, held while HALT.
- state_o  out  2  FSM state (RUN=0, RECOVER=1, HALT=2).

Behaviour:
- Reset (async, active high):
  - state=RECOVER, recover counter=RECOVER_CYC-1.
  - rs0/rs1 credits = RS0_DEPTH/RS1_DEPTH.
  - dispatch_vld_o=0, rm_cnt_o=0, stall_o=0, exc_o=0.
- Dispatch decision is combinational from inputs and registered state; zero-cycle latency to dispatch_vld_o and rm_cnt_o.
- Slot k dispatches iff all of the following hold:
  - state==RUN, ren_rdy_i=1, flush_i=0;
  - slots 0..k-1 dispatch;
  - inst_vld_i[k]=1 and inst_illegal_i[k]=0;
  - (credit of target RS) minus (count of dispatched slots 0..k-1 targeting that RS) > 0.
- The credit check uses registered credit only; same-cycle releases are not visible until the next cycle.
- Credit update, registered: credit_next = credit - dispatched_to_rs + rel_cnt.
  - Saturate at DEPTH.
  - Assertion fires if the unsaturated value exceeds DEPTH or goes negative.
- FSM:
  - RUN -> HALT when the first undispatched slot j has inst_vld_i[j]=1, inst_illegal_i[j]=1, and all slots <j dispatched this cycle (or j=0).
    - exc_o=1 from the next cycle.
    - Legal slots before j still dispatch in the transition cycle.
  - HALT: no dispatch, exc_o=1; leaves only on flush_i.
  - Any state with flush_i=1 -> RECOVER, counter=RECOVER_CYC-1, exc_o cleared next cycle.
    - Credits reload to RS0_DEPTH/RS1_DEPTH; the RS are flushed concurrently and release counts that cycle are ignored.
  - RECOVER: no dispatch; counter decrements each cycle; when counter==0 and flush_i=0 -> RUN next cycle.
    - Flush during RECOVER restarts the counter.
- stall_o=1 only in RUN when inst_vld_i[0]=1 and dispatch_vld_o[0]=0; it is 0 in HALT/RECOVER.
- An empty buffer (inst_vld_i=0) gives rm_cnt_o=0 and stall_o=0.
- A non-prefix inst_vld_i is illegal stimulus: an assertion fires and behaviour is undefined.
- Credit 0 on an RS blocks the first slot targeting it and all younger slots, even those targeting the other RS (strict in-order).

Decomposition:
- Shared package dispatch_pkg: state encoding (ST_RUN/ST_RECOVER/ST_HALT), RS id constants (RS_ID_ALU=0, RS_ID_LSU=1), dispatch width constant DISP_W=4.
- Sub-module rs_credit_cnt (one instance per RS, DEPTH parameter) holding the saturating credit counter, reload-on-flush and overflow assertion.
- The prefix/eligibility logic and FSM stay in dispatch_ctrl.

Test Plan:
- Post-reset, RECOVER_CYC=2, inst_vld_i=1111, all RS0, ren_rdy_i=1 -> dispatch_vld_o=0 for 2 cycles, then 1111, rm_cnt_o=4, rs0_credit_o 8->4.
- rs0 credit=2, rs1 credit=8, inst_rs_id_i=0b0100 (slots 0,1,3 RS0; slot 2 RS1), vld=1111 -> dispatch_vld_o=0111, rm_cnt_o=3, rs0 credit 2->0, rs1 8->7.
- rs0 credit=0 and rs0_rel_cnt_i=3 same cycle, slot0 RS0 -> dispatch_vld_o=0000, stall_o=1; next cycle credit=3 and slot0 dispatches.
- inst_illegal_i=0100, vld=1111, credits ample -> dispatch_vld_o=0011, next cycle state_o=HALT, exc_o=1, dispatch 0 until flush_i; flush -> RECOVER, credits reload to 8/8, exc_o=0.
- ren_rdy_i=0 with vld=1111 -> dispatch_vld_o=0000, credits unchanged; reset asserted mid-RUN with credits 3/5 -> immediately RECOVER, credits 8/8, outputs 0.
